// File: rtl/sram_wr_scheduler.sv
// Chunk-granular round-robin scheduler sharing the SRAM write bus between IFM and filter loaders.
// state | meaning: IDLE wait start_i, ARB pick requester, BURST stream one chunk, DONE session end pulse.
module sram_wr_scheduler #(
  parameter int BUS_SIZE       = 32,
  parameter int DAT_SIZE       = 8,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int IFM_CHUNK_NUM  = 16,
  parameter int FIL_CHUNK_NUM  = 4,
  localparam int DW    = $clog2(WR_DAT_CYC_NUM),
  localparam int MAXC  = (IFM_CHUNK_NUM > FIL_CHUNK_NUM) ? IFM_CHUNK_NUM : FIL_CHUNK_NUM,
  localparam int CW    = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         ifm_valid_i,
  input  logic [BUS_SIZE-1:0]          ifm_sparsemap_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0] ifm_data_i,
  output logic                         ifm_ready_o,
  input  logic                         fil_valid_i,
  input  logic [BUS_SIZE-1:0]          fil_sparsemap_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0] fil_data_i,
  output logic                         fil_ready_o,
  output logic                         wr_valid_o,
  output logic                         wr_sel_o,
  output logic [BUS_SIZE-1:0]          wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0] wr_data_o,
  output logic [DW-1:0]                wr_dat_count_o,
  output logic [CW-1:0]                wr_chunk_count_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CW:0]   IFM_TOT  = (CW+1)'(IFM_CHUNK_NUM);
  localparam logic [CW:0]   FIL_TOT  = (CW+1)'(FIL_CHUNK_NUM);
  localparam logic [DW-1:0] BEAT_END = DW'(WR_DAT_CYC_NUM - 1);

  logic [1:0]                   r_state;
  logic [CW:0]                  r_ifm_cnt;
  logic [CW:0]                  r_fil_cnt;
  logic [DW-1:0]                r_beat;
  logic                         r_grant;
  logic                         r_last;
  logic                         r_wr_valid;
  logic                         r_wr_sel;
  logic [BUS_SIZE-1:0]          r_wr_sm;
  logic [BUS_SIZE*DAT_SIZE-1:0] r_wr_data;
  logic [DW-1:0]                r_wr_dat_cnt;
  logic [CW-1:0]                r_wr_chunk;

  logic          w_ifm_left;
  logic          w_fil_left;
  logic          w_ifm_elig;
  logic          w_fil_elig;
  logic          w_pick_fil;
  logic          w_acc;
  logic [CW-1:0] w_sel_cnt;

  assign w_ifm_left = (r_ifm_cnt < IFM_TOT);
  assign w_fil_left = (r_fil_cnt < FIL_TOT);
  assign w_ifm_elig = ifm_valid_i && w_ifm_left;
  assign w_fil_elig = fil_valid_i && w_fil_left;
  // On a tie the requester not served last wins; r_last=0 means IFM went last.
  assign w_pick_fil = w_fil_elig && (!w_ifm_elig || !r_last);
  assign w_acc      = (r_state == ST_BURST) && (r_grant ? fil_valid_i : ifm_valid_i);
  assign w_sel_cnt  = r_grant ? r_fil_cnt[CW-1:0] : r_ifm_cnt[CW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_ifm_cnt    <= '0;
      r_fil_cnt    <= '0;
      r_beat       <= '0;
      r_grant      <= 1'b0;
      r_last       <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_wr_sm      <= '0;
      r_wr_data    <= '0;
      r_wr_dat_cnt <= '0;
      r_wr_chunk   <= '0;
    end else begin
      r_wr_valid <= w_acc;
      if (w_acc) begin
        r_wr_sel     <= r_grant;
        r_wr_sm      <= r_grant ? fil_sparsemap_i : ifm_sparsemap_i;
        r_wr_data    <= r_grant ? fil_data_i : ifm_data_i;
        r_wr_dat_cnt <= r_beat;
        r_wr_chunk   <= w_sel_cnt;
      end
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_ifm_cnt <= '0;
            r_fil_cnt <= '0;
            r_beat    <= '0;
            r_state   <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (!w_ifm_left && !w_fil_left) begin
            r_state <= ST_DONE;
          end else if (w_ifm_elig || w_fil_elig) begin
            r_grant <= w_pick_fil;
            r_beat  <= '0;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_acc) begin
            if (r_beat == BEAT_END) begin
              r_beat  <= '0;
              r_last  <= r_grant;
              r_state <= ST_ARB;
              if (r_grant) r_fil_cnt <= r_fil_cnt + (CW+1)'(1);
              else         r_ifm_cnt <= r_ifm_cnt + (CW+1)'(1);
            end else begin
              r_beat <= r_beat + DW'(1);
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign ifm_ready_o      = (r_state == ST_BURST) && !r_grant;
  assign fil_ready_o      = (r_state == ST_BURST) && r_grant;
  assign busy_o           = (r_state != ST_IDLE);
  assign done_o           = (r_state == ST_DONE);
  assign wr_valid_o       = r_wr_valid;
  assign wr_sel_o         = r_wr_sel;
  assign wr_sparsemap_o   = r_wr_sm;
  assign wr_data_o        = r_wr_data;
  assign wr_dat_count_o   = r_wr_dat_cnt;
  assign wr_chunk_count_o = r_wr_chunk;

endmodule

// File: tb/tb_sram_wr_scheduler.sv
// Randomized and directed bench for sram_wr_scheduler, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_wr_scheduler;
  localparam int BUS = 32;
  localparam int DSZ = 8;
  localparam int WRN = 4;
  localparam int IFN = 3;
  localparam int FLN = 2;
  localparam int DW  = 2;
  localparam int CW  = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic                ifm_valid_i, fil_valid_i;
  logic [BUS-1:0]      ifm_sparsemap_i, fil_sparsemap_i;
  logic [BUS*DSZ-1:0]  ifm_data_i, fil_data_i;
  logic                ifm_ready_o, fil_ready_o;
  logic                wr_valid_o, wr_sel_o, busy_o, done_o;
  logic [BUS-1:0]      wr_sparsemap_o;
  logic [BUS*DSZ-1:0]  wr_data_o;
  logic [DW-1:0]       wr_dat_count_o;
  logic [CW-1:0]       wr_chunk_count_o;

  sram_wr_scheduler #(.BUS_SIZE(BUS), .DAT_SIZE(DSZ), .WR_DAT_CYC_NUM(WRN),
                      .IFM_CHUNK_NUM(IFN), .FIL_CHUNK_NUM(FLN)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ifm_valid_i(ifm_valid_i), .ifm_sparsemap_i(ifm_sparsemap_i), .ifm_data_i(ifm_data_i),
    .ifm_ready_o(ifm_ready_o),
    .fil_valid_i(fil_valid_i), .fil_sparsemap_i(fil_sparsemap_i), .fil_data_i(fil_data_i),
    .fil_ready_o(fil_ready_o),
    .wr_valid_o(wr_valid_o), .wr_sel_o(wr_sel_o), .wr_sparsemap_o(wr_sparsemap_o),
    .wr_data_o(wr_data_o), .wr_dat_count_o(wr_dat_count_o), .wr_chunk_count_o(wr_chunk_count_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int sess_id;
  int mode;
  int stall_left;
  int src_ch[2];
  int src_bt[2];

  function automatic logic [BUS-1:0] pat_sm(int req, int ch, int bt);
    return {(req == 1) ? 8'hF1 : 8'h1E, 8'(sess_id), 8'(ch), 8'(bt)};
  endfunction

  function automatic logic [BUS*DSZ-1:0] pat_data(int req, int ch, int bt);
    logic [BUS-1:0] s;
    s = pat_sm(req, ch, bt);
    return {4{s, ~s}};
  endfunction

  // Reference model: session phase, delivered chunks per requester, current owner and beat.
  int m_phase;   // 0 idle, 1 arbitrate, 2 streaming, 3 finishing
  int m_cnt[2];
  int m_last, m_owner, m_beat;
  logic                e_valid, e_sel;
  logic [BUS-1:0]      e_sm;
  logic [BUS*DSZ-1:0]  e_data;
  int                  e_dat, e_chunk;

  task automatic model_reset();
    m_phase = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_last = 0; m_owner = 0; m_beat = 0;
    e_valid = 0; e_sel = 0; e_sm = '0; e_data = '0; e_dat = 0; e_chunk = 0;
  endtask

  task automatic model_step(input logic st, input logic iv, input logic fv);
    logic rem0, rem1, el0, el1, v;
    e_valid = 1'b0;
    case (m_phase)
      0: if (st) begin m_cnt[0] = 0; m_cnt[1] = 0; m_phase = 1; end
      1: begin
        rem0 = (m_cnt[0] < IFN); rem1 = (m_cnt[1] < FLN);
        el0 = iv && rem0; el1 = fv && rem1;
        if (!rem0 && !rem1) m_phase = 3;
        else if (el0 || el1) begin
          m_owner = (el0 && el1) ? 1 - m_last : (el1 ? 1 : 0);
          m_beat = 0;
          m_phase = 2;
        end
      end
      2: begin
        v = (m_owner == 1) ? fv : iv;
        if (v) begin
          e_valid = 1'b1;
          e_sel   = (m_owner == 1);
          e_dat   = m_beat;
          e_chunk = m_cnt[m_owner];
          e_sm    = pat_sm(m_owner, m_cnt[m_owner], m_beat);
          e_data  = pat_data(m_owner, m_cnt[m_owner], m_beat);
          m_beat++;
          if (m_beat == WRN) begin
            m_cnt[m_owner]++;
            m_last = m_owner;
            m_phase = 1;
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // Session logs
  int   sess_cyc, n_beats, n_done, done_at, first_ifm_at;
  int   q_sel[$];
  int   q_chunk[$];
  int   f0_dat[$];
  int   f0_at[$];

  task automatic clear_logs();
    sess_cyc = 0; n_beats = 0; n_done = 0; done_at = -1; first_ifm_at = -1;
    q_sel.delete(); q_chunk.delete(); f0_dat.delete(); f0_at.delete();
    src_ch[0] = 0; src_ch[1] = 0; src_bt[0] = 0; src_bt[1] = 0;
  endtask

  task automatic advance(input int r);
    src_bt[r]++;
    if (src_bt[r] == WRN) begin src_bt[r] = 0; src_ch[r]++; end
  endtask

  task automatic do_cycle(input logic st);
    logic iv, fv, acc0, acc1;
    iv = 1'b1; fv = 1'b1;
    case (mode)
      1: if (src_ch[1] == 0 && src_bt[1] == 2 && stall_left > 0) begin fv = 1'b0; stall_left--; end
      2: fv = (src_ch[0] >= 2);
      4: begin iv = ($urandom_range(0, 3) != 0); fv = ($urandom_range(0, 3) != 0); end
      default: ;
    endcase
    start_i = st;
    ifm_valid_i = iv; fil_valid_i = fv;
    ifm_sparsemap_i = pat_sm(0, src_ch[0], src_bt[0]);
    ifm_data_i      = pat_data(0, src_ch[0], src_bt[0]);
    fil_sparsemap_i = pat_sm(1, src_ch[1], src_bt[1]);
    fil_data_i      = pat_data(1, src_ch[1], src_bt[1]);
    acc0 = iv && ifm_ready_o;
    acc1 = fv && fil_ready_o;
    model_step(st, iv, fv);
    @(posedge clk_i);
    @(negedge clk_i);
    if (acc0) advance(0);
    if (acc1) advance(1);
    chk("ifm_ready", 256'(ifm_ready_o), 256'(m_phase == 2 && m_owner == 0));
    chk("fil_ready", 256'(fil_ready_o), 256'(m_phase == 2 && m_owner == 1));
    chk("busy", 256'(busy_o), 256'(m_phase != 0));
    chk("done", 256'(done_o), 256'(m_phase == 3));
    chk("wr_valid", 256'(wr_valid_o), 256'(e_valid));
    chk("wr_sel", 256'(wr_sel_o), 256'(e_sel));
    chk("wr_dat_count", 256'(wr_dat_count_o), 256'(e_dat));
    chk("wr_chunk_count", 256'(wr_chunk_count_o), 256'(e_chunk));
    chk("wr_sparsemap", 256'(wr_sparsemap_o), 256'(e_sm));
    chk("wr_data", 256'(wr_data_o), 256'(e_data));
    if (wr_valid_o) begin
      n_beats++;
      if (wr_dat_count_o == 0) begin q_sel.push_back(int'(wr_sel_o)); q_chunk.push_back(int'(wr_chunk_count_o)); end
      if (wr_sel_o && wr_chunk_count_o == 0) begin f0_dat.push_back(int'(wr_dat_count_o)); f0_at.push_back(sess_cyc); end
      if (!wr_sel_o && first_ifm_at < 0) first_ifm_at = sess_cyc;
    end
    if (done_o) begin n_done++; if (done_at < 0) done_at = sess_cyc; end
    sess_cyc++;
  endtask

  task automatic run_session(input int md, input int start_at);
    int guard;
    mode = md; stall_left = 3; sess_id++;
    clear_logs();
    guard = 0;
    while (n_done == 0 && guard < 300) begin
      do_cycle(guard == start_at);
      guard++;
    end
    chk("session_done", 256'(n_done), 256'(1));
    do_cycle(1'b0);
    do_cycle(1'b0);
    chk("done_pulses", 256'(n_done), 256'(1));
    chk("beat_total", 256'(n_beats), 256'(WRN * (IFN + FLN)));
  endtask

  initial begin
    int exp_sel[5];
    int exp_chk[5];
    rst_i = 1'b1; start_i = 1'b0; ifm_valid_i = 1'b0; fil_valid_i = 1'b0;
    ifm_sparsemap_i = '0; fil_sparsemap_i = '0; ifm_data_i = '0; fil_data_i = '0;
    sess_id = 0; mode = 0; stall_left = 0;
    model_reset(); clear_logs();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_wr_valid", 256'(wr_valid_o), 256'(0));

    // Round robin with both requesters always valid.
    run_session(0, 0);
    exp_sel = '{1, 0, 1, 0, 0};
    exp_chk = '{0, 0, 1, 1, 2};
    chk("rr_chunks", 256'(q_sel.size()), 256'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < q_sel.size()) begin
        chk($sformatf("rr_sel%0d", i), 256'(q_sel[i]), 256'(exp_sel[i]));
        chk($sformatf("rr_chunk%0d", i), 256'(q_chunk[i]), 256'(exp_chk[i]));
      end
    end
    chk("rr_done_at", 256'(done_at), 256'(26));

    // Filter stalls after beat 1 of its first chunk.
    run_session(1, 0);
    chk("stall_beats", 256'(f0_dat.size()), 256'(4));
    if (f0_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("stall_dat%0d", i), 256'(f0_dat[i]), 256'(i));
      chk("stall_gap", 256'(f0_at[2] - f0_at[1] - 1), 256'(3));
      chk("stall_ifm_after", 256'(first_ifm_at > f0_at[3]), 256'(1));
    end

    // IFM alone until it has delivered two chunks.
    run_session(2, 0);
    exp_sel = '{0, 0, 1, 0, 1};
    chk("single_chunks", 256'(q_sel.size()), 256'(5));
    for (int i = 0; i < 5; i++)
      if (i < q_sel.size()) chk($sformatf("single_sel%0d", i), 256'(q_sel[i]), 256'(exp_sel[i]));

    // Start pulse arriving mid-burst is ignored.
    mode = 3; sess_id++; clear_logs();
    do_cycle(1'b1);
    do_cycle(1'b0);
    do_cycle(1'b0);
    do_cycle(1'b1);
    for (int g = 0; g < 300 && n_done == 0; g++) do_cycle(1'b0);
    chk("ign_done_at", 256'(done_at), 256'(26));
    chk("ign_beats", 256'(n_beats), 256'(WRN * (IFN + FLN)));

    // Random valid patterns.
    for (int s = 0; s < 4; s++) run_session(4, $urandom_range(0, 3));

    // Asynchronous reset mid-burst.
    mode = 0; sess_id++; clear_logs();
    do_cycle(1'b1);
    for (int i = 0; i < 6; i++) do_cycle(1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_wr_valid", 256'(wr_valid_o), 256'(0));
    chk("arst_ready", 256'({ifm_ready_o, fil_ready_o}), 256'(0));
    chk("arst_busy_done", 256'({busy_o, done_o}), 256'(0));
    chk("arst_sel_cnt", 256'({wr_sel_o, wr_dat_count_o, wr_chunk_count_o}), 256'(0));
    chk("arst_sm", 256'(wr_sparsemap_o), 256'(0));
    chk("arst_data", 256'(wr_data_o), 256'(0));
    model_reset(); clear_logs();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) do_cycle(1'b0);
    run_session(0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
